// File: rtl/trace_renderer.sv
// trace_renderer: pixel-generation stage for the 4-channel logic analyzer
// VGA path. Fetches one sample word per column, draws four stacked channel
// traces, a dotted grid and a trigger marker, and delays hsync/vsync so that
// RGB and sync leave the block together, two cycles after their inputs.
module trace_renderer #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int LANE_TOP    = 20,
  parameter int LANE_H      = 128,
  parameter int LANE_GAP    = 16,
  parameter int LEVEL_INSET = 16,
  parameter int GRID_X      = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pixel,
  input  logic [9:0]  line,
  input  logic        h_display,
  input  logic        v_display,
  input  logic        h_pulse,
  input  logic        v_pulse,
  input  logic [10:0] trig_col,
  input  logic [3:0]  ch_en,
  output logic [9:0]  sample_addr,
  input  logic [3:0]  sample_data,
  output logic        frame_start,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACTIVE_W = 10'(V_ACTIVE);
  localparam logic [9:0]  LANE_H_W   = 10'(LANE_H);
  localparam logic [9:0]  ROW_HIGH   = 10'(LEVEL_INSET);
  localparam logic [9:0]  ROW_LOW    = 10'(LANE_H - 1 - LEVEL_INSET);
  localparam logic [5:0]  GRID_LAST  = 6'(GRID_X - 1);

  localparam logic [11:0] RGB_MARKER = 12'hF00;
  localparam logic [11:0] RGB_GRID   = 12'h444;
  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_CH0    = 12'hFF0;
  localparam logic [11:0] RGB_CH1    = 12'h0FF;
  localparam logic [11:0] RGB_CH2    = 12'hF0F;
  localparam logic [11:0] RGB_CH3    = 12'h0F0;

  // First line of the lane belonging to channel k.
  function automatic logic [9:0] lane_start(input logic [1:0] k);
    return 10'(LANE_TOP + int'(k) * (LANE_H + LANE_GAP));
  endfunction

  // Frame origin detect and RAM address (address is combinational from pixel).
  logic frame_pos;
  assign frame_pos   = (pixel == 11'd0) && (line == 10'd0);
  assign sample_addr = (pixel < H_ACTIVE_W) ? pixel[9:0] : 10'd0;

  // Per-frame latched controls.
  logic [10:0] trig_col_q;
  logic [3:0]  ch_en_q;

  // Grid column counter.
  logic [5:0] grid_cnt_r;
  logic [5:0] grid_cnt_cur;
  logic [5:0] grid_cnt_nxt;
  logic       grid_now;

  // Stage-1 context registers (aligned with the RAM read in flight).
  logic [10:0] pixel_s1;
  logic [9:0]  line_s1;
  logic        disp_s1;
  logic        hp_s1;
  logic        vp_s1;
  logic        grid_s1;

  // Stage-2 state and combinational colour.
  logic [3:0]  prev_r;
  logic [3:0]  trace_hit;
  logic [11:0] rgb_nxt;

  // Latch trigger column and channel enables only at the frame origin to avoid tearing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_col_q  <= 11'h7FF;
      ch_en_q     <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_pos;
      if (frame_pos) begin
        trig_col_q <= trig_col;
        ch_en_q    <= ch_en;
      end else begin
        trig_col_q <= trig_col_q;
        ch_en_q    <= ch_en_q;
      end
    end
  end

  // Grid counter value for the current column and its successor.
  always_comb begin
    grid_cnt_cur = grid_cnt_r;
    grid_cnt_nxt = grid_cnt_r;
    if (pixel == 11'd0) begin
      grid_cnt_cur = 6'd0;
    end else begin
      grid_cnt_cur = grid_cnt_r;
    end
    if (h_display) begin
      grid_cnt_nxt = (grid_cnt_cur == GRID_LAST) ? 6'd0 : grid_cnt_cur + 6'd1;
    end else begin
      grid_cnt_nxt = grid_cnt_cur;
    end
  end

  // Dotted grid: first column of each GRID_X group, on lines with line[1] clear.
  assign grid_now = (grid_cnt_cur == 6'd0) && !line[1];

  // Grid counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grid_cnt_r <= 6'd0;
    end else begin
      grid_cnt_r <= grid_cnt_nxt;
    end
  end

  // Stage 1: hold pixel context while sample_data is being read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_s1 <= 11'd0;
      line_s1  <= 10'd0;
      disp_s1  <= 1'b0;
      hp_s1    <= 1'b0;
      vp_s1    <= 1'b0;
      grid_s1  <= 1'b0;
    end else begin
      pixel_s1 <= pixel;
      line_s1  <= line;
      disp_s1  <= h_display && v_display;
      hp_s1    <= h_pulse;
      vp_s1    <= v_pulse;
      grid_s1  <= grid_now;
    end
  end

  // Per-channel lane decode and trace drawing (comparators only, no divider).
  always_comb begin
    trace_hit = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] start;
      logic [9:0] row;
      logic       s;
      logic       p;
      start = lane_start(2'(k));
      row   = line_s1 - start;
      s     = sample_data[k];
      // Column 0 has no left neighbour on this line, so no edge is drawn there.
      p     = (pixel_s1 == 11'd0) ? s : prev_r[k];
      if (ch_en_q[k] && (line_s1 >= start) && (line_s1 < start + LANE_H_W)
          && (line_s1 < V_ACTIVE_W)) begin
        trace_hit[k] = (s && (row == ROW_HIGH)) ||
                       (!s && (row == ROW_LOW)) ||
                       ((s != p) && (row >= ROW_HIGH) && (row <= ROW_LOW));
      end else begin
        trace_hit[k] = 1'b0;
      end
    end
  end

  // Colour priority: blanking, marker, traces (ch0 first), grid, background.
  always_comb begin
    rgb_nxt = RGB_BLACK;
    if (!disp_s1) begin
      rgb_nxt = RGB_BLACK;
    end else if (pixel_s1 == trig_col_q) begin
      rgb_nxt = RGB_MARKER;
    end else if (trace_hit[0]) begin
      rgb_nxt = RGB_CH0;
    end else if (trace_hit[1]) begin
      rgb_nxt = RGB_CH1;
    end else if (trace_hit[2]) begin
      rgb_nxt = RGB_CH2;
    end else if (trace_hit[3]) begin
      rgb_nxt = RGB_CH3;
    end else if (grid_s1) begin
      rgb_nxt = RGB_GRID;
    end else begin
      rgb_nxt = RGB_BLACK;
    end
  end

  // Stage 2: register colour and delayed syncs; remember this column's samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red    <= 4'h0;
      green  <= 4'h0;
      blue   <= 4'h0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      prev_r <= 4'b0000;
    end else begin
      red   <= rgb_nxt[11:8];
      green <= rgb_nxt[7:4];
      blue  <= rgb_nxt[3:0];
      hsync <= hp_s1;
      vsync <= vp_s1;
      if (disp_s1) begin
        prev_r <= sample_data;
      end else begin
        prev_r <= prev_r;
      end
    end
  end

endmodule

// File: tb/tb_trace_renderer.sv
// Directed testbench for trace_renderer: drives line sweeps with an 800x600
// style timing pattern, models a 1-cycle-latency sample RAM, captures the
// rendered colour per column and compares selected points with hand values.
module tb_trace_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pixel;
  logic [9:0]  line;
  logic        h_display;
  logic        v_display;
  logic        h_pulse;
  logic        v_pulse;
  logic [10:0] trig_col;
  logic [3:0]  ch_en;
  logic [9:0]  sample_addr;
  logic [3:0]  sample_data;
  logic        frame_start;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;

  logic [3:0]  mem    [0:1023];
  logic [11:0] cap    [0:1055];
  logic        hs_cap [0:1055];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  trace_renderer dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .h_display(h_display), .v_display(v_display),
    .h_pulse(h_pulse), .v_pulse(v_pulse),
    .trig_col(trig_col), .ch_en(ch_en),
    .sample_addr(sample_addr), .sample_data(sample_data),
    .frame_start(frame_start),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync)
  );

  // Sample RAM: read data one cycle after the address.
  always @(posedge clk) sample_data <= mem[sample_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full line 0..1055; cap[c] holds the colour rendered for column c.
  task automatic sweep(input int ln);
    for (int px = 0; px < 1056; px++) begin
      pixel     = 11'(px);
      line      = 10'(ln);
      h_display = (px < 800);
      v_display = (ln < 600);
      h_pulse   = (px >= 840) && (px < 968);
      v_pulse   = (ln >= 601) && (ln < 605);
      @(posedge clk); #1;
      if (px > 0) begin
        cap[px-1]    = {red, green, blue};
        hs_cap[px-1] = hsync;
      end
    end
    h_display = 1'b0;
    h_pulse   = 1'b0;
    @(posedge clk); #1;
    cap[1055]    = {red, green, blue};
    hs_cap[1055] = hsync;
  endtask

  initial begin
    int bad;
    for (int c = 0; c < 1024; c++) begin
      mem[c] = {1'b0, (c >= 100), 1'b1, (c >= 100)};
    end
    rst_n = 1'b0; pixel = 11'd300; line = 10'd180;
    h_display = 1'b1; v_display = 1'b1; h_pulse = 1'b1; v_pulse = 1'b1;
    trig_col = 11'd200; ch_en = 4'b0011;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rgb", {red, green, blue}, 12'h000);
    check_eq("rst_hsync", hsync, 1'b0);
    check_eq("rst_vsync", vsync, 1'b0);
    check_eq("rst_fs", frame_start, 1'b0);

    // Address mapping (combinational).
    pixel = 11'd500; #1; check_eq("addr_500", sample_addr, 10'd500);
    pixel = 11'd799; #1; check_eq("addr_799", sample_addr, 10'd799);
    pixel = 11'd900; #1; check_eq("addr_900", sample_addr, 10'd0);

    // Latency of frame_start (1) and syncs (2).
    rst_n = 1'b1; pixel = 11'd0; line = 10'd0; h_pulse = 1'b1; v_pulse = 1'b1;
    @(posedge clk); #1;
    check_eq("fs_t1", frame_start, 1'b1);
    check_eq("hs_t1", hsync, 1'b0);
    pixel = 11'd1; h_pulse = 1'b0; v_pulse = 1'b0;
    @(posedge clk); #1;
    check_eq("hs_t2", hsync, 1'b1);
    check_eq("vs_t2", vsync, 1'b1);
    check_eq("fs_t2", frame_start, 1'b0);
    @(posedge clk); #1;
    check_eq("hs_t3", hsync, 1'b0);

    // Frame 1: trig 200, ch0+ch1 enabled.
    sweep(0);
    check_eq("l0_c0_grid", cap[0], 12'h444);
    check_eq("l0_c50_grid", cap[50], 12'h444);
    check_eq("l0_c51_bg", cap[51], 12'h000);
    check_eq("l0_c200_mark", cap[200], 12'hF00);
    check_eq("l0_c800_blank", cap[800], 12'h000);
    check_eq("l0_c1000_blank", cap[1000], 12'h000);
    check_eq("l0_hs839", hs_cap[839], 1'b0);
    check_eq("l0_hs840", hs_cap[840], 1'b1);
    check_eq("l0_hs967", hs_cap[967], 1'b1);
    check_eq("l0_hs968", hs_cap[968], 1'b0);

    sweep(2);
    check_eq("l2_c50_nogrid", cap[50], 12'h000);
    check_eq("l2_c200_mark", cap[200], 12'hF00);

    sweep(35);
    check_eq("l35_c100", cap[100], 12'h000);

    sweep(36);
    check_eq("l36_c99", cap[99], 12'h000);
    check_eq("l36_c100_edge", cap[100], 12'hFF0);
    check_eq("l36_c101_high", cap[101], 12'hFF0);
    check_eq("l36_c50_grid", cap[50], 12'h444);

    sweep(80);
    check_eq("l80_c99", cap[99], 12'h000);
    check_eq("l80_c100_edge", cap[100], 12'hFF0);
    check_eq("l80_c101", cap[101], 12'h000);
    check_eq("l80_c150_grid", cap[150], 12'h444);

    sweep(131);
    check_eq("l131_c50_low", cap[50], 12'hFF0);
    check_eq("l131_c99_low", cap[99], 12'hFF0);
    check_eq("l131_c100_edge", cap[100], 12'hFF0);
    check_eq("l131_c101", cap[101], 12'h000);

    sweep(132);
    check_eq("l132_c100_grid", cap[100], 12'h444);
    check_eq("l132_c99", cap[99], 12'h000);

    sweep(180);
    bad = 0;
    for (int c = 0; c < 800; c++) begin
      if (c != 200 && cap[c] !== 12'h0FF) bad++;
    end
    check_eq("l180_row_0ff", bad, 0);
    check_eq("l180_c200_mark", cap[200], 12'hF00);
    check_eq("l180_c800_blank", cap[800], 12'h000);

    // Mid-frame trigger change must not move the marker yet.
    trig_col = 11'd300;
    sweep(250);
    check_eq("l250_c200_mark", cap[200], 12'hF00);
    check_eq("l250_c300", cap[300], 12'h000);

    sweep(292);
    check_eq("l292_c0_grid", cap[0], 12'h444);
    check_eq("l292_c1", cap[1], 12'h000);

    sweep(324);
    check_eq("l324_ch2_off", cap[101], 12'h000);
    check_eq("l324_c100_grid", cap[100], 12'h444);

    sweep(600);
    check_eq("l600_c0", cap[0], 12'h000);
    check_eq("l600_c200", cap[200], 12'h000);

    // Frame 2: new marker position.
    sweep(0);
    check_eq("f2_c300_mark", cap[300], 12'hF00);
    check_eq("f2_c200_grid", cap[200], 12'h444);

    // Mid-line reset.
    pixel = 11'd100; line = 10'd180; h_display = 1'b1; v_display = 1'b1; h_pulse = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_rgb", {red, green, blue}, 12'h0FF);
    check_eq("pre_rst_hs", hsync, 1'b1);
    rst_n = 1'b0; pixel = 11'd0; line = 10'd0;
    @(posedge clk); #1;
    check_eq("mid_rst_rgb", {red, green, blue}, 12'h000);
    check_eq("mid_rst_hs", hsync, 1'b0);
    check_eq("mid_rst_fs", frame_start, 1'b0);
    pixel = 11'd5; line = 10'd180; h_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep(180);
    check_eq("post_rst_c1_notrace", cap[1], 12'h000);
    check_eq("post_rst_c0_grid", cap[0], 12'h444);
    check_eq("post_rst_c300_nomark", cap[300], 12'h444);
    sweep(0);
    sweep(180);
    check_eq("resume_c1_trace", cap[1], 12'h0FF);
    check_eq("resume_c300_mark", cap[300], 12'hF00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
